// File: rtl/writeback_queue_regfile.sv
`default_nettype none
// ============================================================================
// Module   : writeback_queue_regfile
// Purpose  : In-order writeback queue in front of the integer register file,
//            with bypassed combinational read ports and a commit broadcast.
// Revision : 1.0
// ============================================================================
module writeback_queue_regfile #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 6,
  parameter int DEPTH  = 4,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_AW-1:0]          in_rd,
  input  logic                       in_wen,
  input  logic [XLEN-1:0]            in_data,
  input  logic                       wb_stall,
  input  logic [NUM_RD*REG_AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0]     rd_data,
  output logic                       commit_valid,
  output logic [REG_AW-1:0]          commit_rd,
  output logic [XLEN-1:0]            commit_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);
  localparam int c_nreg  = 2**REG_AW;

  logic [REG_AW-1:0]  r_q_rd   [DEPTH];
  logic [XLEN-1:0]    r_q_data [DEPTH];
  logic [DEPTH-1:0]   r_q_wen;
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic [XLEN-1:0]    r_regs   [c_nreg];
  logic               r_commit_valid;
  logic [REG_AW-1:0]  r_commit_rd;
  logic [XLEN-1:0]    r_commit_data;

  logic w_push;
  logic w_pop;
  logic w_head_write;

  assign in_ready     = (r_count != c_cnt_w'(DEPTH));
  assign w_push       = in_valid && in_ready;
  assign w_pop        = (r_count != '0) && !wb_stall;
  assign w_head_write = r_q_wen[r_head] && (r_q_rd[r_head] != '0);

  assign occupancy    = r_count;
  assign commit_valid = r_commit_valid;
  assign commit_rd    = r_commit_rd;
  assign commit_data  = r_commit_data;

  // Payload storage needs no reset: only slots below r_count are ever observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_tail]   <= in_rd;
      r_q_data[r_tail] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q_wen <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_wen[r_tail] <= in_wen;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_nreg; i++) begin
        r_regs[i] <= '0;
      end
      r_commit_valid <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_data  <= '0;
    end else begin
      r_commit_valid <= w_pop && w_head_write;
      if (w_pop && w_head_write) begin
        r_regs[r_q_rd[r_head]] <= r_q_data[r_head];
        r_commit_rd            <= r_q_rd[r_head];
        r_commit_data          <= r_q_data[r_head];
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [REG_AW-1:0]  w_addr;
    logic [XLEN-1:0]    w_val;
    logic [c_ptr_w-1:0] w_idx;

    assign w_addr = rd_addr[g*REG_AW +: REG_AW];

    // Walk oldest to youngest so the last match (the youngest writer) wins.
    always_comb begin
      w_val = r_regs[w_addr];
      w_idx = r_head;
      for (int k = 0; k < DEPTH; k++) begin
        w_idx = r_head + c_ptr_w'(k);
        if ((c_cnt_w'(k) < r_count) && r_q_wen[w_idx] && (r_q_rd[w_idx] == w_addr)) begin
          w_val = r_q_data[w_idx];
        end
      end
      if (w_addr == '0) begin
        w_val = '0;
      end
    end

    assign rd_data[g*XLEN +: XLEN] = w_val;
  end

endmodule
`default_nettype wire
